// File: rtl/rsa_modexp_unit_if.sv
// rtl/rsa_modexp_unit_if.sv - operand/control bundle for rsa_modexp_unit
//
// Purpose: groups the sequencing controls, operands and results of the
// modular-exponentiation core so they travel as one port.
//
// Signals:
//   en      clock enable; low freezes the core
//   run     release; low forces idle, high in idle starts a job
//   mod_n   modulus N
//   base_m  base M
//   exp_e   exponent E
//   result  last completed M^E mod N
//   eoc     end of conversion (level)
//   err     invalid-operand flag, meaningful while eoc is high
//
// Modports: master drives controls/operands, slave is the core.
interface rsa_modexp_unit_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             run;
  logic [WIDTH-1:0] mod_n;
  logic [WIDTH-1:0] base_m;
  logic [WIDTH-1:0] exp_e;
  logic [WIDTH-1:0] result;
  logic             eoc;
  logic             err;

  modport master (
    output en, run, mod_n, base_m, exp_e,
    input  result, eoc, err
  );

  modport slave (
    input  en, run, mod_n, base_m, exp_e,
    output result, eoc, err
  );
endinterface

// File: rtl/rsa_modexp_unit.sv
// rtl/rsa_modexp_unit.sv - iterative modular exponentiation core
//
// Purpose: computes result = base_m^exp_e mod mod_n by left-to-right
// square-and-multiply. Each modular product is formed by a bit-serial
// interleaved multiplier that consumes one multiplier bit per cycle, MSB first.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   rsa_modexp_unit_if.slave (en, run, mod_n, base_m, exp_e in;
//         result, eoc, err out)
//
// Build option: RSA_CONST_TIME_EN - when defined, every exponent bit runs a
// multiply and zero bits discard the product, so latency does not depend on E.
module rsa_modexp_unit #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  rsa_modexp_unit_if.slave  bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [IW-1:0]    bi_q, bi_d;
  logic [IW-1:0]    mc_q, mc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  // Multiplier datapath. The accumulator stays below N, so doubling and
  // adding an operand below N both fit in WIDTH+1 bits.
  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   p_dbl, p_red1, p_add, p_red2;
  logic [WIDTH-1:0] mul_b;
  logic             b_bit;
  logic [WIDTH-1:0] prod;
  logic             go_mul;

  always_comb begin
    n_ext  = {1'b0, n_q};
    // SQR multiplies C by C, MUL multiplies C by M; A is C in both cases.
    mul_b  = (state_q == S_MUL) ? m_q : c_q;
    b_bit  = mul_b[mc_q];
    p_dbl  = p_q << 1;
    p_red1 = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
    p_add  = p_red1 + (b_bit ? {1'b0, c_q} : '0);
    p_red2 = (p_add >= n_ext) ? (p_add - n_ext) : p_add;
    prod   = p_red2[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    m_d      = m_q;
    e_d      = e_q;
    c_d      = c_q;
    p_d      = p_q;
    bi_d     = bi_q;
    mc_d     = mc_q;
    result_d = result_q;
    err_d    = err_q;
    go_mul   = 1'b0;

    if (bus.en) begin
      if (state_q != S_IDLE && !bus.run) begin
        // Abort or release from DONE; result is left as it stands.
        state_d = S_IDLE;
        err_d   = 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.run) state_d = S_LOAD;
          end
          S_LOAD: begin
            n_d      = bus.mod_n;
            m_d      = bus.base_m;
            e_d      = bus.exp_e;
            c_d      = WIDTH'(1);
            p_d      = '0;
            bi_d     = IDX_MAX;
            mc_d     = IDX_MAX;
            result_d = '0;
            err_d    = 1'b0;
            if (bus.mod_n < WIDTH'(2) || bus.base_m >= bus.mod_n) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_SQR;
            end
          end
          S_SQR, S_MUL: begin
            p_d  = p_red2;
            mc_d = mc_q - 1'b1;
            if (mc_q == '0) begin
              // Last multiplier bit: commit the product and restart P.
              p_d  = '0;
              mc_d = IDX_MAX;
              if (state_q == S_SQR) begin
                c_d = prod;
`ifdef RSA_CONST_TIME_EN
                go_mul = 1'b1;
`else
                go_mul = e_q[bi_q];
`endif
              end else begin
`ifdef RSA_CONST_TIME_EN
                // Dummy multiply on zero bits keeps timing independent of E.
                c_d = e_q[bi_q] ? prod : c_q;
`else
                c_d = prod;
`endif
              end
              if (go_mul) begin
                state_d = S_MUL;
              end else if (bi_q == '0) begin
                result_d = c_d;
                state_d  = S_DONE;
              end else begin
                bi_d    = bi_q - 1'b1;
                state_d = S_SQR;
              end
            end
          end
          S_DONE: begin
            // Holds until run falls, handled by the abort branch above.
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      m_q      <= '0;
      e_q      <= '0;
      c_q      <= '0;
      p_q      <= '0;
      bi_q     <= '0;
      mc_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      m_q      <= m_d;
      e_q      <= e_d;
      c_q      <= c_d;
      p_q      <= p_d;
      bi_q     <= bi_d;
      mc_q     <= mc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.eoc    = (state_q == S_DONE);

endmodule
